// File: rtl/search_pkg.sv
// Shared definitions for the binary searcher and the request scheduler in front of it.
package search_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/request_fifo.sv
// Synchronous request FIFO: registered occupancy, no fall-through, pointers wrap modulo depth.
module request_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [DW-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries data only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/search_request_scheduler.sv
// Queues search targets, runs them one at a time on the binary searcher and
// presents each result downstream, keeping saturating done/hit counts.
module search_request_scheduler
    import search_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [DATA_W-1:0] req_target,
    output logic              req_ready,
    input  logic              srch_ready,
    input  logic              srch_done,
    input  logic              srch_found,
    input  logic [ADDR_W-1:0] srch_index,
    output logic              srch_start,
    output logic [DATA_W-1:0] srch_target,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_target,
    output logic              res_found,
    output logic [ADDR_W-1:0] res_index,
    output logic [7:0]        cnt_done,
    output logic [7:0]        cnt_hit
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t            r_state;
    logic [DATA_W-1:0] r_srch_target;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_target;
    logic              r_res_found;
    logic [ADDR_W-1:0] r_res_index;
    logic [7:0]        r_cnt_done;
    logic [7:0]        r_cnt_hit;

    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_issue;
    logic              w_capture;

    request_fifo #(
        .DW    (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (req_valid),
        .i_data  (req_target),
        .i_pop   (w_issue),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign w_issue   = (r_state == S_IDLE) && !w_empty && srch_ready;
    // A finished search is only taken when the result slot is free or draining this cycle.
    assign w_capture = (r_state == S_RUN) && srch_done && (!r_res_valid || res_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_srch_target <= '0;
            r_res_valid   <= 1'b0;
            r_res_target  <= '0;
            r_res_found   <= 1'b0;
            r_res_index   <= '0;
            r_cnt_done    <= '0;
            r_cnt_hit     <= '0;
        end else begin
            if (r_res_valid && res_ready) r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_srch_target <= w_head;
                        r_state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_capture) begin
                        r_res_valid  <= 1'b1;
                        r_res_target <= r_srch_target;
                        r_res_found  <= srch_found;
                        r_res_index  <= srch_found ? srch_index : '0;
                        r_cnt_done   <= sat_inc(r_cnt_done);
                        if (srch_found) r_cnt_hit <= sat_inc(r_cnt_hit);
                        r_state      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (srch_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = !w_full;
    assign srch_start  = (r_state == S_RUN);
    assign srch_target = r_srch_target;
    assign res_valid   = r_res_valid;
    assign res_target  = r_res_target;
    assign res_found   = r_res_found;
    assign res_index   = r_res_index;
    assign cnt_done    = r_cnt_done;
    assign cnt_hit     = r_cnt_hit;

endmodule

// File: doc/search_request_scheduler.md
Name: search_request_scheduler

Overview:
- Sits directly upstream of the binary searcher. It accepts a stream of search targets over a valid/ready interface and buffers them in a small FIFO.
- It issues the targets one at a time to the searcher using the searcher's start/done/ready protocol, then returns each result (target, found, index) downstream over a valid/ready interface.
- It also keeps saturating counts of completed searches and hits for status display.

Parameters:
- DATA_W, 8, width of target/item values
- ADDR_W, 5, width of searcher memory index
- FIFO_DEPTH, 4, request FIFO entries; power of two, >= 2

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high; clock clk
- req_valid  input  1  request target present
- req_target  input  DATA_W  target value to search for
- req_ready  output  1  FIFO can accept (not full)
- srch_ready  input  1  searcher is in IDLE
- srch_done  input  1  searcher finished; held while srch_start is high
- srch_found  input  1  searcher found target; valid while srch_done
- srch_index  input  ADDR_W  searcher's index of the hit; valid while srch_done && srch_found
- srch_start  output  1  start to searcher; held high until done is captured
- srch_target  output  DATA_W  target to searcher; stable while srch_start is high
- res_valid  output  1  result slot holds a result
- res_ready  input  1  downstream consumes the result
- res_target  output  DATA_W  target of the result
- res_found  output  1  hit flag
- res_index  output  ADDR_W  hit index; 0 when res_found=0
- cnt_done  output  8  completed searches, saturates at 255
- cnt_hit  output  8  hits, saturates at 255

Behaviour:
- Reset values: req_ready=1 (FIFO empty); srch_start=0; srch_target=0; res_valid=0; res_target/res_found/res_index=0; cnt_done=cnt_hit=0; state=S_IDLE. Reset mid-search abandons the in-flight search and clears the FIFO. The searcher shares the same reset.
- FIFO: push when req_valid && req_ready. Pop only at issue. Full at FIFO_DEPTH entries; req_ready=!full is combinational from registered occupancy. Pointers wrap modulo FIFO_DEPTH. The occupancy counter is ADDR of log2(FIFO_DEPTH)+1 bits. Push and pop in the same cycle leave occupancy unchanged. A push into an empty FIFO is visible for pop on the next cycle (no fall-through).
- FSM states are S_IDLE, S_RUN and S_RELEASE.
- S_IDLE: if the FIFO is non-empty and srch_ready=1, pop the head, load srch_target and go to S_RUN. Otherwise stay.
- S_RUN: srch_start=1 (decoded from the state register). Capture occurs when srch_done && (!res_valid || res_ready).
  - On capture: load res_* from srch_target/srch_found/srch_index, set res_valid, update counters, go to S_RELEASE.
  - If srch_done=1 but the result slot is blocked, stay in S_RUN with start held. The searcher holds done/found meanwhile.
- S_RELEASE: srch_start=0. Wait for srch_ready=1, then go to S_IDLE. Back-to-back issue therefore has at least one cycle of idle start between searches.
- Latency: a request accepted at cycle 0 gives pop/issue at cycle 1 and srch_start high at cycle 2.
- Result slot: res_valid clears on res_valid && res_ready unless a new capture occurs in the same cycle. A capture with simultaneous consume overwrites the slot and keeps res_valid=1. res_* are stable while res_valid && !res_ready.
- Counters: cnt_done increments on every capture. cnt_hit increments on a capture with srch_found=1. Both hold at 255.
- srch_target holds its value after release until the next issue.
- Only one search is in flight at a time.

Decomposition:
- A shared package search_pkg holds the state enum typedef (S_IDLE, S_RUN, S_RELEASE) and the DATA_W/ADDR_W default constants. The searcher and the scheduler both import it.
- One sub-module is natural: request_fifo (parameterised synchronous FIFO with push/pop, full/empty, head data), instantiated once.

Test Plan:
- Reset, then single request target=100 with a searcher model that returns done at cycle 10, found=1, index=6 -> srch_start rises cycle 2 with srch_target=100; res_valid=1 with res_target=100, res_found=1, res_index=6; cnt_done=1, cnt_hit=1.
- Push 5 targets back-to-back (10,20,30,40,50) with the searcher busy -> req_ready=0 after the 4th held entry. Results emerge in order 10..50 with no loss or duplication.
- Miss case target=7, model returns found=0 -> res_found=0, res_index=0; cnt_hit unchanged, cnt_done incremented.
- res_ready=0 while a second search completes -> srch_start stays high, res_* hold the first result. Raising res_ready captures the second on that cycle and res_valid stays 1.
- Reset asserted mid-S_RUN with 2 entries queued -> next cycle srch_start=0, res_valid=0, req_ready=1, counters=0. No stale target is issued afterward.
- 260 hit searches -> cnt_done=cnt_hit=255 saturated, with no wrap to 0.
